orb_word_reader: RTL and testbench

- Read-side counterpart of the orbit-word RAM writer.
- On a frame request, reads the 12-bit orbit words from the shared orbit RAM at addresses 0..FRAME_LEN-1 and serializes them MSB-first as one continuous NRZ stream.
- Prefetches the next word during the current shift, so consecutive words have no gap.
- Decodes the packed temperature word at TEMP_ADDR and presents it as a parallel value with a valid pulse.

---
 rtl/orb_word_reader.sv | 222 ++++++++++++++++++++++
 tb/tb_orb_word_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/orb_word_reader.sv
// orb_word_reader: reads FRAME_LEN orbit words from the shared orbit RAM and
// streams them MSB-first as one gapless NRZ bit stream. The next word is
// prefetched into a hold register while the current word is shifting. The
// packed temperature word at TEMP_ADDR is decoded onto a parallel output.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   start     frame request (asynchronous level, rising edge starts a frame)
//   rdData    RAM read data, valid 2 cycles after the cycle RE is high
//   rdAddr    RAM read address
//   RE        RAM read enable, one-cycle pulse per word
//   serOut    serial data, bit 11 first
//   wordStb   first clk cycle of bit 11 of every word
//   frameSync first clk cycle of bit 11 of word 0
//   busy      frame in progress
//   tempWord  decoded temperature {w[10:9], w[8:1]}
//   tempValid one-cycle pulse when tempWord updates
//   tempErr   temperature word had w[11] or w[0] set
module orb_word_reader #(
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned TEMP_ADDR = 479,
  parameter int unsigned BIT_DIV   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] rdData,
  output logic [10:0] rdAddr,
  output logic        RE,
  output logic        serOut,
  output logic        wordStb,
  output logic        frameSync,
  output logic        busy,
  output logic [9:0]  tempWord,
  output logic        tempValid,
  output logic        tempErr
);

  localparam int unsigned WORD_W = 12;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned TEMP_W = 10;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, PRIME, SHIFT} state_t;

  state_t              state_q, state_d;
  logic                s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                re_q, re_d;
  logic                re_p1_q, re_p1_d, re_p2_q, re_p2_d;
  logic [ADDR_W-1:0]   word_addr_q, word_addr_d;
  logic                busy_q, busy_d;
  logic [WORD_W-1:0]   sh_q, sh_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                word_stb_q, word_stb_d;
  logic                frame_sync_q, frame_sync_d;
  logic [TEMP_W-1:0]   temp_word_q, temp_word_d;
  logic                temp_valid_q, temp_valid_d;
  logic                temp_err_q, temp_err_d;

  logic                start_rise_c;
  logic                do_load_c;
  logic [WORD_W-1:0]   load_word_c;
  logic [ADDR_W-1:0]   load_addr_c;

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    s1_d         = start;
    s2_d         = s1_q;
    s3_d         = s2_q;
    rd_addr_d    = rd_addr_q;
    re_d         = 1'b0;
    re_p1_d      = re_q;
    re_p2_d      = re_p1_q;
    word_addr_d  = word_addr_q;
    busy_d       = busy_q;
    sh_d         = sh_q;
    hold_d       = hold_q;
    bit_d        = bit_q;
    div_d        = div_q;
    word_stb_d   = 1'b0;
    frame_sync_d = 1'b0;
    temp_word_d  = temp_word_q;
    temp_valid_d = 1'b0;
    temp_err_d   = temp_err_q;
    do_load_c    = 1'b0;
    load_word_c  = '0;
    load_addr_c  = '0;
    start_rise_c = s2_q & ~s3_q;

    case (state_q)
      IDLE: begin
        if (start_rise_c) begin
          rd_addr_d   = '0;
          re_d        = 1'b1;
          word_addr_d = '0;
          busy_d      = 1'b1;
          temp_err_d  = 1'b0;
          state_d     = PRIME;
        end
      end
      PRIME: begin
        // re_p2_q marks the cycle in which the word-0 read data is valid
        if (re_p2_q) begin
          do_load_c   = 1'b1;
          load_word_c = rdData;
          load_addr_c = word_addr_q;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (re_p2_q) begin
          hold_d = rdData;
        end
        // First cycle of a word: prefetch the following one
        if (div_q == '0 && bit_q == BIT_MSB &&
            32'(word_addr_q) < FRAME_LEN - 1) begin
          rd_addr_d = word_addr_q + ADDR_W'(1);
          re_d      = 1'b1;
        end
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q != '0) begin
            bit_d = bit_q - BIT_W'(1);
            sh_d  = {sh_q[WORD_W-2:0], 1'b0};
          end else if (32'(word_addr_q) == FRAME_LEN - 1) begin
            sh_d      = '0;
            busy_d    = 1'b0;
            rd_addr_d = '0;
            state_d   = IDLE;
          end else begin
            do_load_c   = 1'b1;
            load_word_c = hold_q;
            load_addr_c = word_addr_q + ADDR_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Start of a new word: shows bit 11 next cycle with strobes and temp decode
    if (do_load_c) begin
      sh_d         = load_word_c;
      bit_d        = BIT_MSB;
      div_d        = '0;
      word_addr_d  = load_addr_c;
      word_stb_d   = 1'b1;
      frame_sync_d = (load_addr_c == '0);
      if (32'(load_addr_c) == TEMP_ADDR) begin
        temp_word_d  = {load_word_c[10:9], load_word_c[8:1]};
        temp_valid_d = 1'b1;
        temp_err_d   = load_word_c[11] | load_word_c[0];
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      rd_addr_q    <= '0;
      re_q         <= 1'b0;
      re_p1_q      <= 1'b0;
      re_p2_q      <= 1'b0;
      word_addr_q  <= '0;
      busy_q       <= 1'b0;
      sh_q         <= '0;
      hold_q       <= '0;
      bit_q        <= '0;
      div_q        <= '0;
      word_stb_q   <= 1'b0;
      frame_sync_q <= 1'b0;
      temp_word_q  <= '0;
      temp_valid_q <= 1'b0;
      temp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      rd_addr_q    <= rd_addr_d;
      re_q         <= re_d;
      re_p1_q      <= re_p1_d;
      re_p2_q      <= re_p2_d;
      word_addr_q  <= word_addr_d;
      busy_q       <= busy_d;
      sh_q         <= sh_d;
      hold_q       <= hold_d;
      bit_q        <= bit_d;
      div_q        <= div_d;
      word_stb_q   <= word_stb_d;
      frame_sync_q <= frame_sync_d;
      temp_word_q  <= temp_word_d;
      temp_valid_q <= temp_valid_d;
      temp_err_q   <= temp_err_d;
    end
  end

  assign rdAddr    = rd_addr_q;
  assign RE        = re_q;
  assign serOut    = sh_q[WORD_W-1];
  assign wordStb   = word_stb_q;
  assign frameSync = frame_sync_q;
  assign busy      = busy_q;
  assign tempWord  = temp_word_q;
  assign tempValid = temp_valid_q;
  assign tempErr   = temp_err_q;

endmodule

// File: tb/tb_orb_word_reader.sv
// Directed testbench for orb_word_reader with a 2-cycle-latency RAM model.
module tb_orb_word_reader;

  localparam int FL = 4;
  localparam int BD = 2;
  localparam int TA = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] rdData = '0;
  logic [10:0] rdAddr;
  logic        RE;
  logic        serOut;
  logic        wordStb;
  logic        frameSync;
  logic        busy;
  logic [9:0]  tempWord;
  logic        tempValid;
  logic        tempErr;

  orb_word_reader #(.FRAME_LEN(FL), .TEMP_ADDR(TA), .BIT_DIV(BD)) dut (
    .clk(clk), .rst(rst), .start(start), .rdData(rdData), .rdAddr(rdAddr),
    .RE(RE), .serOut(serOut), .wordStb(wordStb), .frameSync(frameSync),
    .busy(busy), .tempWord(tempWord), .tempValid(tempValid), .tempErr(tempErr)
  );

  always #5 clk = ~clk;

  // RAM: data for an RE cycle appears two cycles later
  logic [11:0] mem [0:15];
  logic        p1 = 1'b0;
  logic [10:0] a1 = '0;
  always @(posedge clk) begin
    p1 <= RE;
    a1 <= rdAddr;
    if (p1) rdData <= mem[a1[3:0]];
  end

  int vecs = 0;
  int errs = 0;

  // Results of the most recent captured frame
  int          busy_cyc, shift_cyc, stb_cnt, fs_cnt, tv_cnt;
  bit          fs_bad, ser_bad, timed_out, err_at_start, ser_end;
  int          re_addrs[$];
  logic [11:0] words_got [0:FL-1];

  task automatic run_frame(input int restart_at);
    int cyc;
    int k, w, b;
    bit seen;
    busy_cyc = 0; shift_cyc = 0; stb_cnt = 0; fs_cnt = 0; tv_cnt = 0;
    fs_bad = 0; ser_bad = 0; timed_out = 0; err_at_start = 0; ser_end = 1;
    re_addrs.delete();
    for (int i = 0; i < FL; i++) words_got[i] = '0;
    cyc = 0; seen = 0;
    @(negedge clk);
    start = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) start = 1'b0;
      if (cyc >= 400) begin timed_out = 1; break; end
      if (busy) begin
        if (!seen) err_at_start = tempErr;
        seen = 1;
        busy_cyc++;
      end else if (seen) begin
        ser_end = serOut;
        break;
      end
      if (RE) re_addrs.push_back(int'(rdAddr));
      if (wordStb) stb_cnt++;
      if (frameSync) begin
        fs_cnt++;
        if (!wordStb || stb_cnt != 1) fs_bad = 1;
      end
      if (tempValid) tv_cnt++;
      if (stb_cnt > 0 && busy) begin
        k = shift_cyc;
        shift_cyc++;
        w = k / (12 * BD);
        b = 11 - (k % (12 * BD)) / BD;
        if (w < FL) begin
          if (k % BD == 0) words_got[w][b] = serOut;
          else if (words_got[w][b] !== serOut) ser_bad = 1;
        end
      end
      if (restart_at >= 0 && busy_cyc == restart_at) start = 1'b1;
      if (restart_at >= 0 && busy_cyc == restart_at + 4) start = 1'b0;
    end
  endtask

  task automatic test_reset;
    int act;
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({rdAddr, RE, serOut, wordStb, frameSync, busy, tempWord, tempValid, tempErr} !== 28'd0) begin
      errs++;
      $display("FAIL reset_outputs: got %h expected 0",
               {rdAddr, RE, serOut, wordStb, frameSync, busy, tempWord, tempValid, tempErr});
    end
    rst = 1'b1;
    act = 0;
    repeat (30) begin
      @(negedge clk);
      if (RE || busy || serOut || wordStb || frameSync || tempValid) act++;
    end
    vecs++;
    if (act !== 0) begin
      errs++;
      $display("FAIL idle_quiet: got %0d active cycles expected 0", act);
    end
  endtask

  task automatic test_frame;
    for (int i = 0; i < 16; i++) mem[i] = 12'hA00 + 12'(i);
    run_frame(-1);
    vecs++;
    if (timed_out !== 1'b0) begin errs++; $display("FAIL frame_timeout: got %0b expected 0", timed_out); end
    vecs++;
    if (re_addrs.size() !== FL) begin errs++; $display("FAIL re_count: got %0d expected %0d", re_addrs.size(), FL); end
    for (int i = 0; i < FL; i++) begin
      vecs++;
      if (i < re_addrs.size() && re_addrs[i] !== i) begin
        errs++; $display("FAIL re_addr%0d: got %0d expected %0d", i, re_addrs[i], i);
      end
    end
    for (int i = 0; i < FL; i++) begin
      vecs++;
      if (words_got[i] !== 12'hA00 + 12'(i)) begin
        errs++; $display("FAIL ser_word%0d: got %h expected %h", i, words_got[i], 12'hA00 + 12'(i));
      end
    end
    vecs++;
    if (ser_bad !== 1'b0) begin errs++; $display("FAIL bit_hold: got %0b expected 0", ser_bad); end
    vecs++;
    if (stb_cnt !== FL) begin errs++; $display("FAIL wordstb_count: got %0d expected %0d", stb_cnt, FL); end
    vecs++;
    if (fs_cnt !== 1 || fs_bad !== 1'b0) begin
      errs++; $display("FAIL framesync: got count %0d bad %0b expected 1 0", fs_cnt, fs_bad);
    end
    vecs++;
    if (shift_cyc !== FL * 12 * BD) begin errs++; $display("FAIL shift_cycles: got %0d expected %0d", shift_cyc, FL * 12 * BD); end
    vecs++;
    if (busy_cyc !== FL * 12 * BD + 3) begin errs++; $display("FAIL busy_cycles: got %0d expected %0d", busy_cyc, FL * 12 * BD + 3); end
    vecs++;
    if (ser_end !== 1'b0) begin errs++; $display("FAIL ser_idle: got %0b expected 0", ser_end); end
    vecs++;
    if (tv_cnt !== 1 || tempWord !== 10'h101 || tempErr !== 1'b1) begin
      errs++; $display("FAIL temp_a02: got tv %0d word %h err %0b expected 1 101 1", tv_cnt, tempWord, tempErr);
    end
  endtask

  task automatic test_temp_ok;
    mem[2] = 12'h2A4;
    run_frame(-1);
    vecs++;
    if (err_at_start !== 1'b0) begin errs++; $display("FAIL temperr_clear: got %0b expected 0", err_at_start); end
    vecs++;
    if (tempWord !== 10'h152) begin errs++; $display("FAIL tempword_2a4: got %h expected 152", tempWord); end
    vecs++;
    if (tv_cnt !== 1) begin errs++; $display("FAIL tempvalid_count: got %0d expected 1", tv_cnt); end
    vecs++;
    if (tempErr !== 1'b0) begin errs++; $display("FAIL temperr_2a4: got %0b expected 0", tempErr); end
  endtask

  task automatic test_temp_err;
    mem[2] = 12'h801;
    run_frame(-1);
    vecs++;
    if (tempErr !== 1'b1 || tempWord !== 10'h000) begin
      errs++; $display("FAIL temp_801: got err %0b word %h expected 1 000", tempErr, tempWord);
    end
    run_frame(-1);
    vecs++;
    if (err_at_start !== 1'b0) begin errs++; $display("FAIL temperr_restart: got %0b expected 0", err_at_start); end
    vecs++;
    if (tempErr !== 1'b1) begin errs++; $display("FAIL temperr_again: got %0b expected 1", tempErr); end
  endtask

  task automatic test_restart_ignored;
    mem[2] = 12'hA02;
    run_frame(20);
    vecs++;
    if (busy_cyc !== FL * 12 * BD + 3) begin errs++; $display("FAIL restart_busy: got %0d expected %0d", busy_cyc, FL * 12 * BD + 3); end
    vecs++;
    if (re_addrs.size() !== FL) begin errs++; $display("FAIL restart_re: got %0d expected %0d", re_addrs.size(), FL); end
    vecs++;
    if (stb_cnt !== FL) begin errs++; $display("FAIL restart_stb: got %0d expected %0d", stb_cnt, FL); end
    // A queued restart would start another frame here
    repeat (20) @(negedge clk);
    vecs++;
    if (busy !== 1'b0) begin errs++; $display("FAIL restart_queued: got busy %0b expected 0", busy); end
  endtask

  task automatic test_reset_mid;
    int n, s;
    @(negedge clk);
    start = 1'b1;
    n = 0; s = 0;
    while (s < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 3) start = 1'b0;
      if (wordStb) s++;
    end
    vecs++;
    if (s !== 2) begin errs++; $display("FAIL reach_word1: got %0d strobes expected 2", s); end
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    vecs++;
    if ({rdAddr, RE, serOut, wordStb, frameSync, busy, tempWord, tempValid, tempErr} !== 28'd0) begin
      errs++;
      $display("FAIL midframe_reset: got %h expected 0",
               {rdAddr, RE, serOut, wordStb, frameSync, busy, tempWord, tempValid, tempErr});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(-1);
    vecs++;
    if (re_addrs.size() !== FL || re_addrs[0] !== 0) begin
      errs++; $display("FAIL replay_re: got count %0d expected %0d from addr 0", re_addrs.size(), FL);
    end
    vecs++;
    if (words_got[0] !== 12'hA00 || words_got[FL-1] !== 12'hA03) begin
      errs++; $display("FAIL replay_words: got %h %h expected a00 a03", words_got[0], words_got[FL-1]);
    end
    vecs++;
    if (busy_cyc !== FL * 12 * BD + 3) begin errs++; $display("FAIL replay_busy: got %0d expected %0d", busy_cyc, FL * 12 * BD + 3); end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_frame();
    test_temp_ok();
    test_temp_err();
    test_restart_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
